sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO, successor to the fixed 8-bit x 16 FIFO.
- Width and depth are parameters.
- Simultaneous read and write in one cycle are both accepted.
- Adds programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags.
- Selectable output mode: registered (standard) or first-word fall-through (FWFT).
- Used as the generic buffering primitive between producer/consumer blocks in the same clock domain.

---
 rtl/sync_fifo_param.sv | 97 +++++++++
 tb/tb_sync_fifo_param.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with threshold flags, occupancy count,
// sticky error flags and selectable registered or fall-through output.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 2,
    parameter bit FWFT      = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr,
    input  logic                     rd,
    input  logic [DATA_W-1:0]        din,
    input  logic                     err_clr,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] rdata;
    logic              wr_ok, rd_ok;

    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_THRESH));
    assign almost_empty = (count_q <= CW'(AE_THRESH));
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    assign rdata = mem[rptr_q];

    always_comb begin
        wr_ok   = wr & ~full;
        rd_ok   = rd & ~empty;
        wptr_d  = wptr_q + AW'(wr_ok);
        rptr_d  = rptr_q + AW'(rd_ok);
        count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
        // a fresh error event outranks a clear in the same cycle
        ovf_d   = (ovf_q & ~err_clr) | (wr & full);
        unf_d   = (unf_q & ~err_clr) | (rd & empty);
        dout_d  = dout_q;
        if (rd_ok) begin
            dout_d = rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            dout_q  <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr_q] <= din;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign dout = empty ? '0 : rdata;
        end else begin : g_reg
            assign dout = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: registered instance u0 and
// fall-through instance u1 sharing clock and reset.
module tb_sync_fifo_param;

    logic       clk;
    logic       reset;

    logic       wr0, rd0, clr0;
    logic [7:0] din0, dout0;
    logic       full0, empty0, af0, ae0, ovf0, unf0;
    logic [4:0] cnt0;

    logic       wr1, rd1, clr1;
    logic [7:0] din1, dout1;
    logic       full1, empty1, af1, ae1, ovf1, unf1;
    logic [4:0] cnt1;

    int checks = 0;
    int errors = 0;

    sync_fifo_param #(
        .DATA_W(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(2), .FWFT(1'b0)
    ) u0 (
        .clk(clk), .reset(reset), .wr(wr0), .rd(rd0), .din(din0),
        .err_clr(clr0), .dout(dout0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(cnt0),
        .overflow(ovf0), .underflow(unf0)
    );

    sync_fifo_param #(
        .DATA_W(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(2), .FWFT(1'b1)
    ) u1 (
        .clk(clk), .reset(reset), .wr(wr1), .rd(rd1), .din(din1),
        .err_clr(clr1), .dout(dout1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(cnt1),
        .overflow(ovf1), .underflow(unf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic op0(input logic w, input logic r, input logic c,
                       input logic [7:0] d);
        wr0 = w; rd0 = r; clr0 = c; din0 = d;
        cyc();
        wr0 = 1'b0; rd0 = 1'b0; clr0 = 1'b0;
    endtask

    task automatic op1(input logic w, input logic r, input logic [7:0] d);
        wr1 = w; rd1 = r; din1 = d;
        cyc();
        wr1 = 1'b0; rd1 = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        wr0 = 0; rd0 = 0; clr0 = 0; din0 = 0;
        wr1 = 0; rd1 = 0; clr1 = 0; din1 = 0;
        cyc(); cyc();
        reset = 1'b1;
        cyc();

        chk("rst_count", cnt0, 0);
        chk("rst_empty", empty0, 1);
        chk("rst_full", full0, 0);
        chk("rst_ae", ae0, 1);
        chk("rst_af", af0, 0);
        chk("rst_ovf", ovf0, 0);
        chk("rst_unf", unf0, 0);
        chk("rst_dout", dout0, 0);

        // reset mid-traffic
        for (int i = 0; i < 5; i++) op0(1, 0, 0, 8'h11 + 8'(i));
        op0(0, 1, 0, 0);
        chk("mid_dout_pre", dout0, 8'h11);
        chk("mid_cnt_pre", cnt0, 4);
        #2 reset = 1'b0;
        #1;
        chk("mid_cnt", cnt0, 0);
        chk("mid_empty", empty0, 1);
        chk("mid_ae", ae0, 1);
        chk("mid_dout", dout0, 0);
        #2 reset = 1'b1;
        cyc();
        op0(0, 1, 0, 0);
        chk("mid_rd_unf", unf0, 1);
        chk("mid_rd_dout", dout0, 0);
        chk("mid_rd_cnt", cnt0, 0);
        op0(0, 0, 1, 0);
        chk("unf_clr", unf0, 0);

        // fill
        for (int i = 0; i < 16; i++) begin
            op0(1, 0, 0, 8'(i));
            chk("fill_cnt", cnt0, i + 1);
            chk("fill_af", af0, (i + 1) >= 12);
            chk("fill_full", full0, (i + 1) == 16);
        end
        op0(1, 0, 0, 8'hAA);
        chk("ovf_set", ovf0, 1);
        chk("ovf_cnt", cnt0, 16);

        // drain
        for (int i = 0; i < 16; i++) begin
            op0(0, 1, 0, 0);
            chk("drain_dout", dout0, i);
            chk("drain_cnt", cnt0, 15 - i);
            chk("drain_ae", ae0, (15 - i) <= 2);
        end
        chk("drain_empty", empty0, 1);
        op0(0, 0, 1, 0);
        chk("ovf_clr0", ovf0, 0);

        // simultaneous access at count 5
        for (int i = 0; i < 5; i++) op0(1, 0, 0, 8'h80 + 8'(i));
        for (int i = 0; i < 40; i++) begin
            op0(1, 1, 0, 8'h85 + 8'(i));
            chk("sim_dout", dout0, 8'h80 + i);
            chk("sim_cnt", cnt0, 5);
        end
        for (int i = 0; i < 5; i++) begin
            op0(0, 1, 0, 0);
            chk("sim_tail", dout0, 8'hA8 + i);
        end
        chk("sim_empty", empty0, 1);

        // full corner
        for (int i = 0; i < 16; i++) op0(1, 0, 0, 8'h40 + 8'(i));
        chk("crn_full", full0, 1);
        op0(1, 1, 0, 8'h55);
        chk("crn_full_cnt", cnt0, 15);
        chk("crn_full_ovf", ovf0, 1);
        chk("crn_full_dout", dout0, 8'h40);
        for (int i = 0; i < 15; i++) begin
            op0(0, 1, 0, 0);
            chk("crn_drain", dout0, 8'h41 + i);
        end
        chk("crn_drain_empty", empty0, 1);

        // empty corner
        op0(0, 0, 1, 0);
        op0(1, 1, 0, 8'h66);
        chk("crn_emp_cnt", cnt0, 1);
        chk("crn_emp_unf", unf0, 1);
        chk("crn_emp_dout", dout0, 8'h4F);
        op0(0, 1, 0, 0);
        chk("crn_emp_rd", dout0, 8'h66);
        chk("crn_emp_cnt2", cnt0, 0);

        // sticky errors
        op0(0, 0, 1, 0);
        chk("stk_unf_clr", unf0, 0);
        for (int i = 0; i < 16; i++) op0(1, 0, 0, 8'(i));
        op0(1, 0, 0, 8'hEE);
        chk("stk_ovf_set", ovf0, 1);
        op0(0, 0, 1, 0);
        chk("stk_ovf_clr", ovf0, 0);
        op0(1, 0, 1, 8'hEE);
        chk("stk_ovf_win", ovf0, 1);
        chk("stk_cnt", cnt0, 16);

        // fall-through instance
        chk("fw_rst_dout", dout1, 0);
        chk("fw_rst_empty", empty1, 1);
        op1(1, 0, 8'h3C);
        chk("fw_first", dout1, 8'h3C);
        chk("fw_first_cnt", cnt1, 1);
        op1(1, 0, 8'h3D);
        chk("fw_hold", dout1, 8'h3C);
        op1(0, 1, 0);
        chk("fw_pop1", dout1, 8'h3D);
        chk("fw_pop1_cnt", cnt1, 1);
        op1(0, 1, 0);
        chk("fw_pop2_empty", empty1, 1);
        chk("fw_pop2_dout", dout1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
